// File: rtl/pong_ball_engine.sv
// pong_ball_engine
//   Ball physics and scoring for the Pong game. The ball moves once per
//   frame_tick while run is high, bounces off the top/bottom walls and the
//   paddles, and a miss on either side awards a point to the opposite player.
//   First player to WIN_SCORE ends the game; restart clears the match.
//
//   Optional feature macro: BALL_SPEEDUP_EN
//     defined   : each paddle hit raises the per-frame step by 1, capped at
//                 SPEED_MAX; step returns to SPEED on every serve/restart/reset
//     undefined : step stays at SPEED
//
// Ports
//   clk          master clock
//   clr_n        asynchronous active-low reset
//   frame_tick   one-clk pulse per frame
//   run          high while the game is in PLAY
//   restart      one-clk restart pulse (beats every other same-cycle event)
//   paddle1_y    top edge of the left paddle
//   paddle2_y    top edge of the right paddle
//   ball_x       ball left edge
//   ball_y       ball top edge
//   ball_visible high while serving or moving
//   p1, p2       player scores
//   point_pulse  one-clk pulse when a point is scored
//   game_over    high once a player reaches WIN_SCORE
//   winner       0 = p1 won, 1 = p2 won (valid with game_over)
module pong_ball_engine #(
   parameter int unsigned H_RES        = 640,
   parameter int unsigned V_RES        = 480,
   parameter int unsigned BALL_SIZE    = 8,
   parameter int unsigned PADDLE_W     = 8,
   parameter int unsigned PADDLE_H     = 64,
   parameter int unsigned P1_X         = 16,
   parameter int unsigned P2_X         = 616,
   parameter int unsigned SPEED        = 2,
   parameter int unsigned SPEED_MAX    = 6,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned WIN_SCORE    = 7
) (
   input  logic       clk,
   input  logic       clr_n,
   input  logic       frame_tick,
   input  logic       run,
   input  logic       restart,
   input  logic [9:0] paddle1_y,
   input  logic [9:0] paddle2_y,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic       ball_visible,
   output logic [2:0] p1,
   output logic [2:0] p2,
   output logic       point_pulse,
   output logic       game_over,
   output logic       winner
);

`ifdef BALL_SPEEDUP_EN
   localparam bit SPEEDUP = 1'b1;
`else
   localparam bit SPEEDUP = 1'b0;
`endif

   localparam logic [9:0]  CX      = 10'((H_RES - BALL_SIZE) / 2);
   localparam logic [9:0]  CY      = 10'((V_RES - BALL_SIZE) / 2);
   localparam logic [9:0]  Y_MAX   = 10'(V_RES - BALL_SIZE);
   localparam logic [9:0]  X_LHIT  = 10'(P1_X + PADDLE_W);
   localparam logic [9:0]  X_RHIT  = 10'(P2_X - BALL_SIZE);
   localparam logic [10:0] BS_W    = 11'(BALL_SIZE);
   localparam logic [10:0] PH_W    = 11'(PADDLE_H);
   localparam logic [10:0] HRES_W  = 11'(H_RES);
   localparam logic [10:0] VRES_W  = 11'(V_RES);
   localparam logic [10:0] LFACE_W = 11'(P1_X + PADDLE_W);
   localparam logic [10:0] RFACE_W = 11'(P2_X);
   localparam logic [3:0]  STEP0   = 4'(SPEED);
   // With speed-up disabled the cap equals the base step, so a hit leaves it unchanged.
   localparam logic [3:0]  STEP_CAP = SPEEDUP ? 4'(SPEED_MAX) : 4'(SPEED);
   localparam int unsigned CNT_W   = $clog2(SERVE_FRAMES + 1);
   localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES);
   localparam logic [2:0]  WIN     = 3'(WIN_SCORE);

   typedef enum logic [2:0] {IDLE, SERVE, MOVE, SCORED, OVER} state_t;

   state_t           state;
   logic             dx_right;
   logic             dy_down;
   logic             serve_dy;   // dy used by the most recent serve
   logic             scorer;     // 0 = p1 scored, 1 = p2 scored
   logic [CNT_W-1:0] serve_cnt;
   logic [3:0]       step;

   logic [10:0] x_w, y_w, step_w, p1y_w, p2y_w;
   logic [9:0]  step10;
   logic [9:0]  x_next, y_next;
   logic        dx_next, dy_next;
   logic        ov1, ov2, hit, miss;
   logic [2:0]  cur_score, new_score;

   always_comb begin
      x_w    = {1'b0, ball_x};
      y_w    = {1'b0, ball_y};
      p1y_w  = {1'b0, paddle1_y};
      p2y_w  = {1'b0, paddle2_y};
      step_w = 11'(step);
      step10 = 10'(step);
   end

   // Vertical motion with wall bounce
   always_comb begin
      y_next  = ball_y;
      dy_next = dy_down;
      if (!dy_down && (y_w < step_w)) begin
         y_next  = '0;
         dy_next = 1'b1;
      end else if (dy_down && (y_w + BS_W + step_w > VRES_W)) begin
         y_next  = Y_MAX;
         dy_next = 1'b0;
      end else if (dy_down) begin
         y_next = ball_y + step10;
      end else begin
         y_next = ball_y - step10;
      end
   end

   // Horizontal motion, paddle hits and misses (overlap uses pre-update y)
   always_comb begin
      ov1     = (y_w + BS_W > p1y_w) && (y_w < p1y_w + PH_W);
      ov2     = (y_w + BS_W > p2y_w) && (y_w < p2y_w + PH_W);
      hit     = 1'b0;
      miss    = 1'b0;
      x_next  = ball_x;
      dx_next = dx_right;
      if (!dx_right) begin
         // x - step <= face rewritten as x <= face + step to avoid underflow
         if ((x_w >= LFACE_W) && (x_w <= LFACE_W + step_w) && ov1) begin
            hit     = 1'b1;
            x_next  = X_LHIT;
            dx_next = 1'b1;
         end else if (x_w < step_w) begin
            miss = 1'b1;
         end else begin
            x_next = ball_x - step10;
         end
      end else begin
         if ((x_w + BS_W <= RFACE_W) && (x_w + BS_W + step_w >= RFACE_W) && ov2) begin
            hit     = 1'b1;
            x_next  = X_RHIT;
            dx_next = 1'b0;
         end else if (x_w + BS_W + step_w > HRES_W) begin
            miss = 1'b1;
         end else begin
            x_next = ball_x + step10;
         end
      end
   end

   always_comb begin
      cur_score = scorer ? p2 : p1;
      new_score = (cur_score == 3'd7) ? 3'd7 : cur_score + 3'd1;
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state        <= IDLE;
         ball_x       <= CX;
         ball_y       <= CY;
         ball_visible <= 1'b0;
         p1           <= '0;
         p2           <= '0;
         point_pulse  <= 1'b0;
         game_over    <= 1'b0;
         winner       <= 1'b0;
         dx_right     <= 1'b1;
         dy_down      <= 1'b1;
         serve_dy     <= 1'b1;
         scorer       <= 1'b0;
         serve_cnt    <= '0;
         step         <= STEP0;
      end else begin
         point_pulse <= 1'b0;
         if (restart) begin
            // Direction registers are deliberately left untouched
            state        <= IDLE;
            ball_x       <= CX;
            ball_y       <= CY;
            ball_visible <= 1'b0;
            p1           <= '0;
            p2           <= '0;
            game_over    <= 1'b0;
            winner       <= 1'b0;
            serve_cnt    <= '0;
            step         <= STEP0;
         end else begin
            unique case (state)
               IDLE: begin
                  ball_x <= CX;
                  ball_y <= CY;
                  if (run) begin
                     state        <= SERVE;
                     serve_cnt    <= SERVE_LOAD;
                     serve_dy     <= dy_down;
                     ball_visible <= 1'b1;
                  end
               end
               SERVE: begin
                  if (frame_tick && run) begin
                     serve_cnt <= serve_cnt - 1'b1;
                     if (serve_cnt == CNT_W'(1)) begin
                        state <= MOVE;
                        step  <= STEP0;
                     end
                  end
               end
               MOVE: begin
                  if (frame_tick && run) begin
                     if (miss) begin
                        // Ball freezes where it left the field
                        state        <= SCORED;
                        point_pulse  <= 1'b1;
                        scorer       <= ~dx_right;
                        ball_visible <= 1'b0;
                     end else begin
                        ball_x   <= x_next;
                        ball_y   <= y_next;
                        dx_right <= dx_next;
                        dy_down  <= dy_next;
                        if (hit) begin
                           step <= (step >= STEP_CAP) ? STEP_CAP : step + 4'd1;
                        end
                     end
                  end
               end
               SCORED: begin
                  if (scorer) begin
                     p2 <= new_score;
                  end else begin
                     p1 <= new_score;
                  end
                  if (new_score == WIN) begin
                     state     <= OVER;
                     game_over <= 1'b1;
                     winner    <= scorer;
                  end else begin
                     // Serve toward the player who conceded, alternating vertical direction
                     state        <= SERVE;
                     ball_x       <= CX;
                     ball_y       <= CY;
                     dx_right     <= ~scorer;
                     dy_down      <= ~serve_dy;
                     serve_dy     <= ~serve_dy;
                     serve_cnt    <= SERVE_LOAD;
                     step         <= STEP0;
                     ball_visible <= 1'b1;
                  end
               end
               OVER: begin
                  ball_visible <= 1'b0;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pong_ball_engine.sv
module tb_pong_ball_engine;
   logic       clk = 1'b0;
   logic       clr_n, frame_tick, run, restart;
   logic [9:0] paddle1_y, paddle2_y;
   logic [9:0] ball_x, ball_y;
   logic       ball_visible, point_pulse, game_over, winner;
   logic [2:0] p1, p2;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   pong_ball_engine dut (
      .clk          (clk),
      .clr_n        (clr_n),
      .frame_tick   (frame_tick),
      .run          (run),
      .restart      (restart),
      .paddle1_y    (paddle1_y),
      .paddle2_y    (paddle2_y),
      .ball_x       (ball_x),
      .ball_y       (ball_y),
      .ball_visible (ball_visible),
      .p1           (p1),
      .p2           (p2),
      .point_pulse  (point_pulse),
      .game_over    (game_over),
      .winner       (winner)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check_xy(input string tag, input int ex, input int ey);
      check({tag, "_x"}, int'(ball_x), ex);
      check({tag, "_y"}, int'(ball_y), ey);
   endtask

   // Serve to the right, paddle2 out of the path: miss after 159 moves
   task automatic rally_right(input int exp_p1);
      ticks(60);
      check_xy("rally_serve", 316, 236);
      ticks(158);
      check("rally_pre_miss_x", int'(ball_x), 632);
      tick();
      check("rally_pulse", int'(point_pulse), 1);
      @(negedge clk);
      check("rally_pulse_width", int'(point_pulse), 0);
      check("rally_p1", int'(p1), exp_p1);
   endtask

   initial begin
      clr_n = 1'b1; frame_tick = 1'b0; run = 1'b0; restart = 1'b0;
      paddle1_y = 10'd150; paddle2_y = 10'd400;
      @(negedge clk) clr_n = 1'b0;
      @(negedge clk);
      check_xy("reset", 316, 236);
      check("reset_vis", int'(ball_visible), 0);
      check("reset_p1", int'(p1), 0);
      check("reset_p2", int'(p2), 0);
      check("reset_pulse", int'(point_pulse), 0);
      check("reset_over", int'(game_over), 0);
      check("reset_winner", int'(winner), 0);
      clr_n = 1'b1;
      @(negedge clk);
      check("idle_vis", int'(ball_visible), 0);

      // First serve: down/right
      run = 1'b1;
      @(negedge clk);
      check("serve_vis", int'(ball_visible), 1);
      ticks(59);
      check_xy("serve59", 316, 236);
      tick();
      check_xy("serve_end", 316, 236);
      tick();
      check_xy("move1", 318, 238);
      ticks(117);
      check_xy("move118", 552, 472);
      tick();
      check_xy("bottom_hold", 554, 472);
      tick();
      check_xy("bottom_bounce", 556, 470);
      ticks(25);
      check_xy("pre_rhit", 606, 420);
      tick();
      check_xy("rhit", 608, 418);
      check("rhit_pulse", int'(point_pulse), 0);

      // Leftward leg: top bounce then left paddle hit
      paddle2_y = 10'd180;
      ticks(209);
      check_xy("top_reach", 190, 0);
      tick();
      check_xy("top_hold", 188, 0);
      tick();
      check_xy("top_bounce", 186, 2);
      ticks(80);
      check_xy("pre_lhit", 26, 162);
      tick();
      check_xy("lhit", 24, 164);
      check("lhit_pulse", int'(point_pulse), 0);

      // Back right, hit paddle2 again, then left miss
      paddle1_y = 10'd0;
      ticks(291);
      check_xy("pre_rhit2", 606, 200);
      tick();
      check_xy("rhit2", 608, 198);
      ticks(304);
      check_xy("pre_lmiss", 0, 408);
      tick();
      check("lmiss_pulse", int'(point_pulse), 1);
      check("lmiss_p2_pending", int'(p2), 0);
      @(negedge clk);
      check("lmiss_pulse_width", int'(point_pulse), 0);
      check("lmiss_p2", int'(p2), 1);
      check_xy("reserve", 316, 236);
      check("reserve_vis", int'(ball_visible), 1);

      // Second serve: left and up; p1 returns it, p2 misses
      paddle1_y = 10'd40;
      paddle2_y = 10'd200;
      ticks(60);
      check_xy("s2_serve", 316, 236);
      tick();
      check_xy("s2_move1", 314, 234);
      ticks(144);
      check_xy("s2_pre_lhit", 26, 52);
      tick();
      check_xy("s2_lhit", 24, 54);
      ticks(304);
      check_xy("s2_pre_rmiss", 632, 284);
      tick();
      check("s2_pulse", int'(point_pulse), 1);
      @(negedge clk);
      check("s2_p1", int'(p1), 1);
      check("s2_p2", int'(p2), 1);

      for (int p = 2; p <= 7; p++) rally_right(p);
      check("over_flag", int'(game_over), 1);
      check("over_winner", int'(winner), 0);
      check("over_vis", int'(ball_visible), 0);
      check("over_p2", int'(p2), 1);
      ticks(3);
      check("over_hold_p1", int'(p1), 7);
      check("over_hold_p2", int'(p2), 1);
      check("over_hold_flag", int'(game_over), 1);
      check("over_hold_vis", int'(ball_visible), 0);

      // Restart out of OVER
      run = 1'b0;
      @(negedge clk) restart = 1'b1;
      @(negedge clk) restart = 1'b0;
      check("rst_p1", int'(p1), 0);
      check("rst_p2", int'(p2), 0);
      check("rst_over", int'(game_over), 0);
      check("rst_vis", int'(ball_visible), 0);
      check_xy("rst_ball", 316, 236);

      // New game keeps last direction (right, down); pause while moving
      run = 1'b1;
      @(negedge clk);
      check("g2_vis", int'(ball_visible), 1);
      ticks(60);
      ticks(5);
      check_xy("g2_move5", 326, 246);
      run = 1'b0;
      ticks(10);
      check_xy("g2_paused", 326, 246);
      run = 1'b1;
      ticks(153);
      check("g2_pre_miss_x", int'(ball_x), 632);

      // Restart lands on the same clk as the miss
      @(negedge clk);
      frame_tick = 1'b1;
      restart    = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      restart    = 1'b0;
      run        = 1'b0;
      check("rmiss_pulse", int'(point_pulse), 0);
      check("rmiss_vis", int'(ball_visible), 0);
      check_xy("rmiss_ball", 316, 236);
      @(negedge clk);
      check("rmiss_p1", int'(p1), 0);
      check("rmiss_pulse2", int'(point_pulse), 0);
      check("rmiss_idle_vis", int'(ball_visible), 0);
      check("rmiss_over", int'(game_over), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pong_ball_engine.md
Name: pong_ball_engine

Overview:
- Ball physics and scoring stage for the Pong game.
- Consumes paddle top-edge positions from the joystick-to-paddle path and a per-frame tick from the VGA timing path.
- Produces the ball position for the VGA renderer.
- Produces the p1/p2 scores and the game-over flag consumed by the score display and the game state machine.
- Every position update happens once per frame.

Parameters:
- H_RES, 640, visible width in pixels
- V_RES, 480, visible height in pixels
- BALL_SIZE, 8, ball side length in pixels (ball is square, position is its top-left corner)
- PADDLE_W, 8, paddle width in pixels
- PADDLE_H, 64, paddle height in pixels
- P1_X, 16, left edge of the left paddle
- P2_X, 616, left edge of the right paddle
- SPEED, 2, per-frame step on each axis, in pixels
- SPEED_MAX, 6, step ceiling; used only with BALL_SPEEDUP_EN
- SERVE_FRAMES, 60, frames the ball is held at centre before each serve
- WIN_SCORE, 7, score that ends the game; must be 7 or less

Ports:
- clk, in, 1, master clock
- clr_n, in, 1, asynchronous active-low reset
- frame_tick, in, 1, one-clk pulse per frame at vsync start
- run, in, 1, high while the game state is PLAY
- restart, in, 1, debounced one-clk restart pulse
- paddle1_y, in, 10, top edge of the left paddle
- paddle2_y, in, 10, top edge of the right paddle
- ball_x, out, 10, ball left edge
- ball_y, out, 10, ball top edge
- ball_visible, out, 1, high in SERVE and MOVE
- p1, out, 3, left player score
- p2, out, 3, right player score
- point_pulse, out, 1, one-clk pulse when a point is scored
- game_over, out, 1, high in OVER
- winner, out, 1, 0 means p1 won, 1 means p2 won; valid while game_over is high

Behaviour:
- Reset (clr_n low, asynchronous):
  - state = IDLE; p1 = p2 = 0; point_pulse = 0; game_over = 0; winner = 0.
  - ball at centre: CX = (H_RES-BALL_SIZE)/2 = 316, CY = (V_RES-BALL_SIZE)/2 = 236.
  - dx = right, dy = down, serve counter = 0, step = SPEED.
- All outputs are registered. Geometry compares use 11-bit unsigned arithmetic so sums cannot overflow.
- States: IDLE, SERVE, MOVE, SCORED, OVER.
- IDLE: ball at centre, ball_visible = 0. When run is high, go to SERVE and load serve counter = SERVE_FRAMES.
- SERVE: ball at centre.
  - Each frame_tick with run high decrements the counter.
  - On the tick where the counter reaches 0, go to MOVE with step = SPEED.
- MOVE: on each frame_tick with run high, evaluate the Y and X axes independently within the same clk. Both axes apply in the same update.
- Y axis:
  - dy up and y < step: y = 0, dy = down.
  - dy down and y+BALL_SIZE+step > V_RES: y = V_RES-BALL_SIZE, dy = up.
  - Otherwise y moves by ±step.
- Paddle overlap test for paddle N: y+BALL_SIZE > paddleN_y and y < paddleN_y+PADDLE_H. Use y before this frame's update.
- X axis, left side (dx left):
  - Hit: x >= P1_X+PADDLE_W, x-step <= P1_X+PADDLE_W, and overlap with paddle 1. Result: x = P1_X+PADDLE_W, dx = right.
  - Miss: x < step. Result: p2 scores.
- X axis, right side (dx right):
  - Hit: x+BALL_SIZE <= P2_X, x+BALL_SIZE+step >= P2_X, and overlap with paddle 2. Result: x = P2_X-BALL_SIZE, dx = left.
  - Miss: x+BALL_SIZE+step > H_RES. Result: p1 scores.
- Otherwise x moves by ±step.
- Scoring: a miss enters SCORED; the ball is frozen and point_pulse is high for exactly one clk.
- SCORED, on the next clk:
  - Increment the scorer's count, saturating at 7.
  - If the new count equals WIN_SCORE: go to OVER and set winner.
  - Otherwise: go to SERVE with the ball at centre, dx pointing toward the player who conceded, dy toggled from the previous serve, and serve counter = SERVE_FRAMES.
- OVER: ball_visible = 0; scores hold; leave only via restart.
- run low: frame_tick is ignored in SERVE and MOVE, so the ball freezes. SCORED still completes.
- restart, from any state:
  - same values as reset, except dx/dy keep their current value;
  - restart has priority over every other same-cycle event, including a miss or a frame_tick.
- frame_tick outside SERVE and MOVE has no effect.

Optional Feature:
- Macro: BALL_SPEEDUP_EN.
- Defined: each paddle hit sets step = min(step+1, SPEED_MAX), effective from the next frame. Step resets to SPEED on every serve, restart and reset.
- Undefined: step is constant SPEED and SPEED_MAX is unused.

Test Plan:
- Reset, run=1, 60 frame_ticks: serve ends and the game is in MOVE. After one more tick, ball = (318, 238).
- Ball at y=1, dy up, one frame_tick: ball_y = 0 and dy = down. With the ball at x=300, x still moves by 2 in the same update.
- Ball at x=25, dx left, paddle1_y=200, ball_y=220, one tick: x = 24, dx = right, no point_pulse. Repeat with paddle1_y=0: miss at x<2, point_pulse is one clk wide, p2 = 1, next serve has dx = left.
- p1=6, ball misses on the right side: p1 = 7, game_over = 1, winner = 0. Further frame_ticks leave everything unchanged. restart then gives p1 = p2 = 0, IDLE, game_over = 0.
- run held low during MOVE for 10 frame_ticks: ball_x and ball_y unchanged. restart asserted on the same clk as a miss: no score change, state = IDLE.
- With BALL_SPEEDUP_EN defined, 5 consecutive paddle hits: step goes 3, 4, 5, 6, 6. After the next serve, step = 2.
